fetch_queue: RTL

//   Small in-order instruction buffer between instruction_fetch and the decode stage.

---
 rtl/fetch_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Shared widths for the fetch/decode datapath, followed by the in-order
// fetch queue that sits between instruction fetch and decode.
package common;
  localparam int unsigned PROGRAM_ADDRESS_WIDTH = 32;
  localparam int unsigned INSTRUCTION_WIDTH     = 32;
endpackage

// Circular FIFO of {pc, instruction} pairs; flush drops wrong-path entries.
module fetch_queue
  import common::*;
#(
  parameter int unsigned                  DEPTH     = 4,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = 32'h13
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PROGRAM_ADDRESS_WIDTH-1:0] in_pc,
  input  logic [INSTRUCTION_WIDTH-1:0]     in_instr,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] out_pc,
  output logic [INSTRUCTION_WIDTH-1:0]     out_instr,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_q    [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0]     instr_q [DEPTH];
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             full;
  logic                             push;
  logic                             pop;

  assign full      = (count_q == FULL_CNT);
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_pc    = out_valid ? pc_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
  assign count     = count_q;

  // Next pointer/count: flush clears, otherwise push and pop advance independently.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Control state register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; no reset needed since out_valid gates the outputs.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_q[wr_ptr_q]    <= in_pc;
      instr_q[wr_ptr_q] <= in_instr;
    end
  end

  // Occupancy consistency checks (simulation only).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= FULL_CNT);
      assert ((count_q == '0) == ((wr_ptr_q == rd_ptr_q) && !full));
    end
  end

endmodule
